// File: rtl/serial_shift_driver_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_shift_driver_pkg
// Description : Shared state encoding and sizing helpers for serial_shift_driver
// Revision    : 1.0 - initial release
// ============================================================================
package serial_shift_driver_pkg;

    localparam int c_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_HIGH   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    function automatic int bit_cnt_w(input int n_bytes);
        return $clog2(c_BYTE_W * n_bytes + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_shift_driver_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_shift_driver_if
// Description : Host request/status and downstream 74LS164 pins of the driver
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_shift_driver_if #(
    parameter int N_BYTES = 1
);
    logic [8*N_BYTES-1:0] DIN;
    logic                 LOAD;
    logic                 CLR;
    logic                 BUSY;
    logic                 DONE;
    logic                 SCP;
    logic                 SDA;
    logic                 SMR_n;

    modport master (
        output DIN, LOAD, CLR,
        input  BUSY, DONE, SCP, SDA, SMR_n
    );

    modport slave (
        input  DIN, LOAD, CLR,
        output BUSY, DONE, SCP, SDA, SMR_n
    );
endinterface
`default_nettype wire

// File: rtl/serial_clk_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_clk_divider
// Description : Terminal-count pulse every CLK_DIV cycles, restartable
// Revision    : 1.0 - initial release
// ============================================================================
module serial_clk_divider #(
    parameter int CLK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_restart,
    output logic      o_tc
);
    localparam int                 c_CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_tc;

    assign w_tc = (r_cnt == c_LAST);
    assign o_tc = w_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || w_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/serial_shift_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_shift_driver
// Description : MSB-first serialiser driving cascaded 74LS164 shift registers
// Revision    : 1.0 - initial release
// ============================================================================
module serial_shift_driver #(
    parameter int DELAY   = 10,
    parameter int CLK_DIV = 4,
    parameter int N_BYTES = 1
) (
    input  wire logic           CP,
    input  wire logic           MR_n,
    serial_shift_driver_if.slave bus
);
    import serial_shift_driver_pkg::*;

    localparam int                  c_NBITS   = c_BYTE_W * N_BYTES;
    localparam int                  c_BCNT_W  = bit_cnt_w(N_BYTES);
    localparam logic [c_BCNT_W-1:0] c_NBITS_V = c_BCNT_W'(c_NBITS);
    localparam logic [c_BCNT_W-1:0] c_ONE     = c_BCNT_W'(1);

    state_t              r_state;
    logic [c_NBITS-1:0]  r_shift;
    logic [c_BCNT_W-1:0] r_bits;
    logic                r_busy;
    logic                r_done;
    logic                r_scp;
    logic                r_sda;
    logic                r_smr_n;
    logic                w_tc;
    logic                w_restart;

    // Divider holds at zero while no timed phase is active, so every phase
    // entered from IDLE starts with a full CLK_DIV count.
    assign w_restart = (r_state == ST_IDLE) || (r_state == ST_FINISH);

    serial_clk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk       (CP),
        .rst_n     (MR_n),
        .i_restart (w_restart),
        .o_tc      (w_tc)
    );

    always_ff @(posedge CP or negedge MR_n) begin
        if (!MR_n) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_bits  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_scp   <= 1'b0;
            r_sda   <= 1'b0;
            r_smr_n <= 1'b0;
        end else begin
            // Outputs are decoded from the current state, one edge behind it.
            r_busy  <= (r_state == ST_CLEAR) || (r_state == ST_SETUP) || (r_state == ST_HIGH);
            r_done  <= (r_state == ST_FINISH);
            r_scp   <= (r_state == ST_HIGH);
            r_sda   <= ((r_state == ST_SETUP) || (r_state == ST_HIGH)) && r_shift[c_NBITS-1];
            r_smr_n <= (r_state != ST_CLEAR);

            case (r_state)
                ST_IDLE: begin
                    if (bus.CLR) begin
                        r_state <= ST_CLEAR;
                    end else if (bus.LOAD) begin
                        r_shift <= bus.DIN;
                        r_bits  <= c_NBITS_V;
                        r_state <= ST_SETUP;
                    end
                end
                ST_CLEAR: begin
                    if (w_tc) r_state <= ST_IDLE;
                end
                ST_SETUP: begin
                    if (w_tc) r_state <= ST_HIGH;
                end
                ST_HIGH: begin
                    if (w_tc) begin
                        r_shift <= {r_shift[c_NBITS-2:0], 1'b0};
                        r_bits  <= r_bits - c_ONE;
                        r_state <= (r_bits == c_ONE) ? ST_FINISH : ST_SETUP;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign #(DELAY) bus.BUSY  = r_busy;
    assign #(DELAY) bus.DONE  = r_done;
    assign #(DELAY) bus.SCP   = r_scp;
    assign #(DELAY) bus.SDA   = r_sda;
    assign #(DELAY) bus.SMR_n = r_smr_n;
endmodule
`default_nettype wire

// File: tb/tb_serial_shift_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_serial_shift_driver
// Description : Directed self-checking bench with behavioural 74LS164 chains
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_shift_driver;

    localparam int c_DELAY = 2;

    logic CP;
    logic MR_n;

    serial_shift_driver_if #(.N_BYTES(1)) if0 ();
    serial_shift_driver_if #(.N_BYTES(2)) if1 ();
    serial_shift_driver_if #(.N_BYTES(1)) if2 ();

    serial_shift_driver #(.DELAY(c_DELAY), .CLK_DIV(2), .N_BYTES(1)) u_dut0 (.CP(CP), .MR_n(MR_n), .bus(if0));
    serial_shift_driver #(.DELAY(c_DELAY), .CLK_DIV(2), .N_BYTES(2)) u_dut1 (.CP(CP), .MR_n(MR_n), .bus(if1));
    serial_shift_driver #(.DELAY(c_DELAY), .CLK_DIV(1), .N_BYTES(1)) u_dut2 (.CP(CP), .MR_n(MR_n), .bus(if2));

    initial begin
        CP = 1'b0;
        forever #10 CP = ~CP;
    end

    // Downstream 74LS164 chains (DSB tied high); bit 0 is nearest the driver.
    logic [7:0]  q0 = 8'h00;
    logic [15:0] q1 = 16'h0000;
    logic [7:0]  q2 = 8'h00;
    int pulses0 = 0;
    int pulses1 = 0;
    int pulses2 = 0;

    always @(posedge if0.SCP or negedge if0.SMR_n)
        if (!if0.SMR_n) q0 <= 8'h00; else q0 <= {q0[6:0], if0.SDA};
    always @(posedge if1.SCP or negedge if1.SMR_n)
        if (!if1.SMR_n) q1 <= 16'h0000; else q1 <= {q1[14:0], if1.SDA};
    always @(posedge if2.SCP or negedge if2.SMR_n)
        if (!if2.SMR_n) q2 <= 8'h00; else q2 <= {q2[6:0], if2.SDA};
    always @(posedge if0.SCP) pulses0 <= pulses0 + 1;
    always @(posedge if1.SCP) pulses1 <= pulses1 + 1;
    always @(posedge if2.SCP) pulses2 <= pulses2 + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic get_busy(input int d);
        case (d) 0: return if0.BUSY; 1: return if1.BUSY; default: return if2.BUSY; endcase
    endfunction
    function automatic logic get_done(input int d);
        case (d) 0: return if0.DONE; 1: return if1.DONE; default: return if2.DONE; endcase
    endfunction
    function automatic logic get_scp(input int d);
        case (d) 0: return if0.SCP; 1: return if1.SCP; default: return if2.SCP; endcase
    endfunction
    function automatic logic get_sda(input int d);
        case (d) 0: return if0.SDA; 1: return if1.SDA; default: return if2.SDA; endcase
    endfunction
    function automatic logic get_smr(input int d);
        case (d) 0: return if0.SMR_n; 1: return if1.SMR_n; default: return if2.SMR_n; endcase
    endfunction
    function automatic logic [15:0] get_q(input int d);
        case (d) 0: return {8'h00, q0}; 1: return q1; default: return {8'h00, q2}; endcase
    endfunction
    function automatic int get_pulses(input int d);
        case (d) 0: return pulses0; 1: return pulses1; default: return pulses2; endcase
    endfunction

    task automatic set_din(input int d, input logic [15:0] v);
        case (d) 0: if0.DIN = v[7:0]; 1: if1.DIN = v; default: if2.DIN = v[7:0]; endcase
    endtask
    task automatic set_load(input int d, input logic v);
        case (d) 0: if0.LOAD = v; 1: if1.LOAD = v; default: if2.LOAD = v; endcase
    endtask
    task automatic set_clr(input int d, input logic v);
        case (d) 0: if0.CLR = v; 1: if1.CLR = v; default: if2.CLR = v; endcase
    endtask

    typedef struct {
        int          dut;
        logic [15:0] din;
        logic [15:0] exp_q;
        int          exp_edge;
        int          exp_pulses;
        int          inj_load_at;
        int          inj_clr_at;
    } vec_t;

    // Called at a negedge with the target DUT idle; returns at a negedge.
    task automatic run_vec(input vec_t v, input string tag);
        int cd, p0, first_done, ndone, hi_run, lo_run, bad_hi, bad_lo;
        logic s, prev, seen_hi, busy1;
        cd = (v.dut == 2) ? 1 : 2;
        p0 = get_pulses(v.dut);
        first_done = -1; ndone = 0; hi_run = 0; lo_run = 0;
        bad_hi = 0; bad_lo = 0; prev = 1'b0; seen_hi = 1'b0; busy1 = 1'b0;
        set_din(v.dut, v.din);
        set_load(v.dut, 1'b1);
        @(posedge CP);
        @(negedge CP);
        set_load(v.dut, 1'b0);
        for (int n = 1; n <= v.exp_edge + 6; n++) begin
            @(posedge CP);
            @(negedge CP);
            if (n == 1) busy1 = get_busy(v.dut);
            if (get_done(v.dut)) begin
                ndone++;
                if (first_done < 0) first_done = n;
            end
            s = get_scp(v.dut);
            if (s) begin
                if (!prev && seen_hi && lo_run != cd) bad_lo++;
                hi_run++;
            end else begin
                if (prev) begin
                    if (hi_run != cd) bad_hi++;
                    seen_hi = 1'b1;
                    lo_run  = 0;
                end
                lo_run++;
                hi_run = 0;
            end
            prev = s;
            if (n == v.inj_load_at)     begin set_din(v.dut, 16'h0000); set_load(v.dut, 1'b1); end
            if (n == v.inj_load_at + 1) set_load(v.dut, 1'b0);
            if (n == v.inj_clr_at)      set_clr(v.dut, 1'b1);
            if (n == v.inj_clr_at + 1)  set_clr(v.dut, 1'b0);
        end
        check({tag, " busy_at_edge1"}, 32'(busy1), 32'd1);
        check({tag, " done_edge"},     32'(first_done), 32'(v.exp_edge));
        check({tag, " done_count"},    32'(ndone), 32'd1);
        check({tag, " downstream_q"},  32'(get_q(v.dut)), 32'(v.exp_q));
        check({tag, " scp_pulses"},    32'(get_pulses(v.dut) - p0), 32'(v.exp_pulses));
        check({tag, " scp_high_width"}, 32'(bad_hi), 32'd0);
        check({tag, " scp_low_width"},  32'(bad_lo), 32'd0);
        check({tag, " busy_after"},    32'(get_busy(v.dut)), 32'd0);
    endtask

    task automatic run_clear(input logic with_load, input string tag);
        int p0, nlow, nbusy, ndone;
        p0 = pulses0; nlow = 0; nbusy = 0; ndone = 0;
        set_din(0, 16'h0055);
        if0.CLR  = 1'b1;
        if0.LOAD = with_load;
        @(posedge CP);
        @(negedge CP);
        if0.CLR  = 1'b0;
        if0.LOAD = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge CP);
            @(negedge CP);
            if (!if0.SMR_n) nlow++;
            if (if0.BUSY)   nbusy++;
            if (if0.DONE)   ndone++;
        end
        check({tag, " smr_low_cycles"}, 32'(nlow), 32'd2);
        check({tag, " busy_cycles"},    32'(nbusy), 32'd2);
        check({tag, " downstream_q"},   32'(q0), 32'h00);
        check({tag, " scp_pulses"},     32'(pulses0 - p0), 32'd0);
        check({tag, " done_count"},     32'(ndone), 32'd0);
    endtask

    vec_t vecs[7];
    vec_t vlate;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   p0, ndone, budget;
        logic found;

        vecs[0] = '{dut: 0, din: 16'h00A5, exp_q: 16'h00A5, exp_edge: 33, exp_pulses: 8,  inj_load_at: -5, inj_clr_at: -5};
        vecs[1] = '{dut: 1, din: 16'h12C3, exp_q: 16'h12C3, exp_edge: 65, exp_pulses: 16, inj_load_at: -5, inj_clr_at: -5};
        vecs[2] = '{dut: 2, din: 16'h00F0, exp_q: 16'h00F0, exp_edge: 17, exp_pulses: 8,  inj_load_at: -5, inj_clr_at: -5};
        vecs[3] = '{dut: 0, din: 16'h003C, exp_q: 16'h003C, exp_edge: 33, exp_pulses: 8,  inj_load_at: 10, inj_clr_at: -5};
        vecs[4] = '{dut: 0, din: 16'h003C, exp_q: 16'h003C, exp_edge: 33, exp_pulses: 8,  inj_load_at: -5, inj_clr_at: 12};
        vecs[5] = '{dut: 1, din: 16'h8001, exp_q: 16'h8001, exp_edge: 65, exp_pulses: 16, inj_load_at: -5, inj_clr_at: -5};
        vecs[6] = '{dut: 0, din: 16'h00FF, exp_q: 16'h00FF, exp_edge: 33, exp_pulses: 8,  inj_load_at: -5, inj_clr_at: -5};

        MR_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            set_din(d, 16'h0000);
            set_load(d, 1'b0);
            set_clr(d, 1'b0);
        end
        repeat (3) @(negedge CP);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset%0d busy", d),  32'(get_busy(d)), 32'd0);
            check($sformatf("reset%0d done", d),  32'(get_done(d)), 32'd0);
            check($sformatf("reset%0d scp", d),   32'(get_scp(d)),  32'd0);
            check($sformatf("reset%0d sda", d),   32'(get_sda(d)),  32'd0);
            check($sformatf("reset%0d smr_n", d), 32'(get_smr(d)),  32'd0);
        end
        MR_n = 1'b1;
        repeat (2) @(negedge CP);
        check("post_reset smr_n", 32'(if0.SMR_n), 32'd1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Downstream now holds 8'hFF from the last vector.
        run_clear(1'b0, "clear");
        run_clear(1'b1, "clear_with_load");

        // Reset while SCP is high on the third bit of 8'hE7 (SDA=1 there).
        p0 = pulses0;
        set_din(0, 16'h00E7);
        if0.LOAD = 1'b1;
        @(posedge CP);
        @(negedge CP);
        if0.LOAD = 1'b0;
        found = 1'b0;
        budget = 0;
        while (!found && budget < 40) begin
            @(posedge CP);
            @(negedge CP);
            budget++;
            if ((pulses0 - p0) == 3 && if0.SCP) found = 1'b1;
        end
        check("midreset reached_third_bit", 32'(found), 32'd1);
        check("midreset sda_before", 32'(if0.SDA), 32'd1);
        MR_n = 1'b0;
        #(c_DELAY + 1);
        check("midreset scp",   32'(if0.SCP),   32'd0);
        check("midreset sda",   32'(if0.SDA),   32'd0);
        check("midreset busy",  32'(if0.BUSY),  32'd0);
        check("midreset smr_n", 32'(if0.SMR_n), 32'd0);
        check("midreset downstream_q", 32'(q0), 32'h00);
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge CP);
            if (n == 5) MR_n = 1'b1;
            if (if0.DONE) ndone++;
        end
        check("midreset no_done", 32'(ndone), 32'd0);

        vlate = '{dut: 0, din: 16'h0081, exp_q: 16'h0081, exp_edge: 33, exp_pulses: 8, inj_load_at: -5, inj_clr_at: -5};
        run_vec(vlate, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
